// File: rtl/conv_mac_if.sv
// Handshake and configuration bundle for conv_mac_seq.
// slave = the MAC sequencer, master = the upstream/config agent.
interface conv_mac_if #(
   parameter int ACT_W  = 8,
   parameter int WGT_W  = 16,
   parameter int N_TAPS = 27,
   parameter int N_OUT  = 8,
   parameter int ACC_W  = 32
);
   localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

   logic                      in_valid;
   logic                      in_ready;
   logic [N_TAPS*ACT_W-1:0]   in_act;
   logic                      out_valid;
   logic                      out_ready;
   logic [N_OUT*ACT_W-1:0]    out_act;
   logic                      wld_valid;
   logic [TAP_W-1:0]          wld_tap;
   logic [N_OUT*WGT_W-1:0]    wld_data;
   logic                      bld_valid;
   logic [N_OUT*ACC_W-1:0]    bld_data;
   logic                      cfg_ready;

   modport slave (
      input  in_valid, in_act, out_ready,
      input  wld_valid, wld_tap, wld_data, bld_valid, bld_data,
      output in_ready, out_valid, out_act, cfg_ready
   );

   modport master (
      output in_valid, in_act, out_ready,
      output wld_valid, wld_tap, wld_data, bld_valid, bld_data,
      input  in_ready, out_valid, out_act, cfg_ready
   );
endinterface

// File: rtl/conv_mac_seq.sv
// Sequential convolution MAC: one tap per cycle across N_OUT channels,
// bias preload, arithmetic shift and selectable activation on completion.
//
// state | meaning
// IDLE  | waiting for an activation vector; weight/bias writes accepted
// BUSY  | accumulating one tap per cycle for all channels
// DONE  | result held on out_act until out_ready
module conv_mac_seq #(
   parameter int ACT_W    = 8,
   parameter int WGT_W    = 16,
   parameter int N_TAPS   = 27,
   parameter int N_OUT    = 8,
   parameter int ACC_W    = 32,
   parameter int SHIFT    = 15,
   parameter int ACT_MODE = 2,
   parameter int CLIP_MAX = 6
) (
   input logic      clk,
   input logic      rstn,
   conv_mac_if.slave bus
);
   localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int PRD_W = ACT_W + WGT_W;
   localparam logic [TAP_W-1:0]        LAST_TAP = TAP_W'(N_TAPS - 1);
   localparam logic signed [ACC_W-1:0] ACT_HI   = ACC_W'(2 ** (ACT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] ACT_LO   = ~ACT_HI;
   localparam logic signed [ACC_W-1:0] CLIP     = ACC_W'(CLIP_MAX);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state;
   logic [TAP_W-1:0]        tap;
   logic                    in_rdy_q;
   logic                    cfg_q;
   logic                    ov_q;
   logic [N_OUT*ACT_W-1:0]  out_q;

   logic signed [WGT_W-1:0] wgt      [N_TAPS][N_OUT];
   logic signed [ACC_W-1:0] bias     [N_OUT];
   logic signed [ACC_W-1:0] bias_eff [N_OUT];
   logic signed [ACC_W-1:0] acc      [N_OUT];
   logic signed [ACC_W-1:0] acc_nxt  [N_OUT];
   logic signed [PRD_W-1:0] prod     [N_OUT];
   logic signed [ACT_W-1:0] act_q    [N_TAPS];

   assign bus.in_ready  = in_rdy_q;
   assign bus.cfg_ready = cfg_q;
   assign bus.out_valid = ov_q;
   assign bus.out_act   = out_q;

   function automatic logic [ACT_W-1:0] activate(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      logic signed [ACC_W-1:0] r;
      s = a >>> SHIFT;
      if (ACT_MODE == 0)
         r = (s > ACT_HI) ? ACT_HI : ((s < ACT_LO) ? ACT_LO : s);
      else if (ACT_MODE == 1)
         r = s[ACC_W-1] ? '0 : ((s > ACT_HI) ? ACT_HI : s);
      else
         r = s[ACC_W-1] ? '0 : ((s > CLIP) ? CLIP : s);
      return r[ACT_W-1:0];
   endfunction

   // A bias written in the accepting cycle must land in the preload directly.
   always_comb begin
      for (int c = 0; c < N_OUT; c++) begin
         bias_eff[c] = (cfg_q && bus.bld_valid) ? bus.bld_data[c*ACC_W +: ACC_W] : bias[c];
         prod[c]     = wgt[tap][c] * act_q[tap];
         acc_nxt[c]  = acc[c] + ACC_W'(prod[c]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int t = 0; t < N_TAPS; t++)
            for (int c = 0; c < N_OUT; c++)
               wgt[t][c] <= '0;
         for (int c = 0; c < N_OUT; c++)
            bias[c] <= '0;
      end else if (cfg_q) begin
         if (bus.wld_valid && (bus.wld_tap <= LAST_TAP))
            for (int c = 0; c < N_OUT; c++)
               wgt[bus.wld_tap][c] <= bus.wld_data[c*WGT_W +: WGT_W];
         if (bus.bld_valid)
            for (int c = 0; c < N_OUT; c++)
               bias[c] <= bus.bld_data[c*ACC_W +: ACC_W];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         tap      <= '0;
         in_rdy_q <= 1'b1;
         cfg_q    <= 1'b1;
         ov_q     <= 1'b0;
         out_q    <= '0;
         for (int c = 0; c < N_OUT; c++)
            acc[c] <= '0;
         for (int t = 0; t < N_TAPS; t++)
            act_q[t] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int t = 0; t < N_TAPS; t++)
                     act_q[t] <= bus.in_act[t*ACT_W +: ACT_W];
                  for (int c = 0; c < N_OUT; c++)
                     acc[c] <= bias_eff[c];
                  tap      <= '0;
                  state    <= BUSY;
                  in_rdy_q <= 1'b0;
                  cfg_q    <= 1'b0;
               end
            end
            BUSY: begin
               for (int c = 0; c < N_OUT; c++)
                  acc[c] <= acc_nxt[c];
               if (tap == LAST_TAP) begin
                  // Activate the final sum directly so out_act is ready with out_valid.
                  for (int c = 0; c < N_OUT; c++)
                     out_q[c*ACT_W +: ACT_W] <= activate(acc_nxt[c]);
                  tap   <= '0;
                  state <= DONE;
                  ov_q  <= 1'b1;
               end else begin
                  tap <= tap + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state    <= IDLE;
                  ov_q     <= 1'b0;
                  in_rdy_q <= 1'b1;
                  cfg_q    <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               ov_q     <= 1'b0;
               in_rdy_q <= 1'b1;
               cfg_q    <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: doc/conv_mac_seq.md
CONV_MAC_SEQ -- requirements
Module: conv_mac_seq

Interface
REQ-001 Parameter ACT_W, default 8, activation width, signed two's complement.
REQ-002 Parameter WGT_W, default 16, weight width, signed.
REQ-003 Parameter N_TAPS, default 27, taps per output (kernel area times input channels); minimum 2.
REQ-004 Parameter N_OUT, default 8, output channels computed in parallel.
REQ-005 Parameter ACC_W, default 32, accumulator width, signed.
REQ-006 Parameter SHIFT, default 15, arithmetic right shift applied to the accumulator before activation.
REQ-007 Parameter ACT_MODE, default 2, activation select: 0 = signed saturate, 1 = ReLU, 2 = clipped ReLU.
REQ-008 Parameter CLIP_MAX, default 6, upper clip value for ACT_MODE 2.
REQ-009 clk  input  1  clock; all state changes on the rising edge.
REQ-010 rstn  input  1  reset, asynchronous, active-low.
REQ-011 in_valid / in_ready  input / output  1 / 1  activation-vector handshake.
REQ-012 in_act  input  N_TAPS*ACT_W  activation vector; tap t occupies bits [t*ACT_W +: ACT_W].
REQ-013 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-014 out_act  output  N_OUT*ACT_W  results; channel c occupies bits [c*ACT_W +: ACT_W].
REQ-015 wld_valid  input  1  weight-row write strobe.
REQ-016 wld_tap  input  clog2(N_TAPS)  tap index of the weight row being written.
REQ-017 wld_data  input  N_OUT*WGT_W  weights of that tap for all channels, channel c at [c*WGT_W +: WGT_W].
REQ-018 bld_valid / bld_data  input / input  1 / N_OUT*ACC_W  bias write strobe and per-channel biases.
REQ-019 cfg_ready  output  1  high only in IDLE; weight and bias writes are accepted only while it is high.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-021 In IDLE, a cycle with in_valid=1 SHALL capture in_act, load acc[c]=bias[c] for every c, clear the tap counter, and enter BUSY.
REQ-022 In BUSY, each cycle SHALL update acc[c] += W[tap][c] * in_act[tap] for every c, as a signed full-precision product sign-extended to ACC_W, with the sum wrapping modulo 2^ACC_W.
REQ-023 The tap counter SHALL increment once per BUSY cycle; the cycle with tap==N_TAPS-1 SHALL transition to DONE.
REQ-024 out_valid SHALL rise exactly N_TAPS cycles after the accepting edge.
REQ-025 out_act[c] SHALL be derived from s = acc[c] >>> SHIFT as follows.
  - Mode 0: clamp s to [-2^(ACT_W-1), 2^(ACT_W-1)-1].
  - Mode 1: s<0 gives 0; otherwise clamp s to 2^(ACT_W-1)-1.
  - Mode 2: s<0 gives 0; s>CLIP_MAX gives CLIP_MAX; otherwise s.
REQ-026 In DONE, out_act SHALL stay stable while out_ready=0; out_valid&&out_ready SHALL return the FSM to IDLE.
REQ-027 in_valid asserted outside IDLE SHALL be ignored; the upstream must hold it until in_ready=1.
REQ-028 An input accepted in IDLE SHALL use the weights and biases as they stand at the accepting edge, including any write made in that same cycle.
REQ-029 wld_valid or bld_valid while cfg_ready=0 SHALL be dropped with no state change.
REQ-030 wld_tap >= N_TAPS SHALL be dropped.
REQ-031 Weights and biases SHALL persist across any number of inputs until rewritten.

Reset
REQ-032 rstn=0 SHALL force the following, at any time including mid-BUSY or in DONE:
  - state = IDLE, tap counter = 0;
  - acc, captured in_act, all weights and all biases = 0;
  - out_valid=0, out_act=0, in_ready=1, cfg_ready=1.
REQ-033 After rstn deasserts, the first in_valid SHALL be accepted on the first rising edge.

Verification (defaults, bias 0)
REQ-034 All weights 16384, all acts +2 -> out_valid after 27 cycles; mode 2 gives every channel 6; mode 1 gives 27.
REQ-035 All weights 16384, all acts -2 -> mode 0 gives -27 (0xE5) per channel; modes 1 and 2 give 0.
REQ-036 All weights 32767, all acts 127 -> mode 0 and mode 1 give 127; mode 2 gives 6.
REQ-037 out_ready held low 5 cycles in DONE -> out_valid stays 1, out_act unchanged, in_ready=0; a wld_valid write in that window is dropped, so the next run is unchanged.
REQ-038 rstn pulsed at tap 10 of BUSY -> all outputs are 0 and the FSM is in IDLE; a following run with no reload gives 0 in modes 1 and 2.
REQ-039 Two back-to-back inputs with out_ready tied 1 -> in_ready returns high the cycle after the DONE handshake; the second result is independent of the first.
